// File: rtl/direction_cmd_fsm.sv
// Direction command stage: conditions four raw push-buttons (synchronise,
// debounce, rising-edge detect), resolves simultaneous presses by priority
// and holds the latched direction with enable high for a fixed time.
module direction_cmd_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       stop,
  output logic       enable,
  output logic [1:0] direc,
  output logic       change_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [1:0]      direc_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            change_n;

  logic [3:0]      sync1, sync2;
  logic [3:0]      db, db_q;
  logic [DW-1:0]   dbcnt [4];
  logic [3:0]      press;
  logic            has_press;
  logic [1:0]      press_code;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: level flips once sync2 has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int unsigned i = 0; i < 4; i++) dbcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (dbcnt[i] == DB_LAST) begin
            db[i]    <= ~db[i];
            dbcnt[i] <= '0;
          end else begin
            dbcnt[i] <= dbcnt[i] + 1'b1;
          end
        end else begin
          dbcnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_q <= '0;
    else        db_q <= db;
  end

  // Press events and priority encoding: forward > reverse > left > right.
  always_comb begin
    press      = db & ~db_q;
    has_press  = |press;
    press_code = 2'd3;
    if      (press[0]) press_code = 2'd0;
    else if (press[1]) press_code = 2'd1;
    else if (press[2]) press_code = 2'd2;
  end

  // Next-state logic: stop beats press, press beats timeout.
  always_comb begin
    state_n = state;
    direc_n = direc;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (!stop && has_press) begin
          state_n = MOVING;
          direc_n = press_code;
          hold_n  = '0;
        end
      end
      MOVING: begin
        if (stop) begin
          state_n = IDLE;
        end else if (has_press) begin
          direc_n = press_code;
          hold_n  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = IDLE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    change_n = ((state_n == MOVING) != (state == MOVING)) || (direc_n != direc);
  end

  // State, latched direction, hold counter and change strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      direc        <= '0;
      hold_cnt     <= '0;
      change_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      direc        <= direc_n;
      hold_cnt     <= hold_n;
      change_pulse <= change_n;
    end
  end

  assign enable = (state == MOVING);

endmodule

// File: tb/tb_direction_cmd_fsm.sv
// Randomised and directed bench for direction_cmd_fsm against a timestamp-based
// behavioural model (enable deadline = acceptance edge + HOLD).
module tb_direction_cmd_fsm;

  localparam int unsigned D = 4;
  localparam int unsigned H = 20;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       stop;
  logic       enable;
  logic [1:0] direc;
  logic       change_pulse;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  direction_cmd_fsm #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .stop         (stop),
    .enable       (enable),
    .direc        (direc),
    .change_pulse (change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int unsigned m_n;
  bit [3:0]    m_s1, m_s2, m_lvl, m_prev;
  int unsigned m_run [4];
  bit          m_en;
  bit [1:0]    m_dir;
  bit          m_pulse;
  int unsigned m_deadline;

  function automatic void model_reset();
    m_n = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_en = 0; m_dir = '0; m_pulse = 0; m_deadline = 0;
  endfunction

  function automatic void model_edge(bit [3:0] b, bit st);
    bit [3:0] pr;
    bit       en0;
    bit [1:0] d0;
    m_n++;
    pr  = m_lvl & ~m_prev;
    en0 = m_en;
    d0  = m_dir;
    if (st) begin
      m_en = 0;
    end else if (pr != 0) begin
      if      (pr[0]) m_dir = 2'd0;
      else if (pr[1]) m_dir = 2'd1;
      else if (pr[2]) m_dir = 2'd2;
      else            m_dir = 2'd3;
      m_en       = 1;
      m_deadline = m_n + H;
    end else if (m_en && m_n == m_deadline) begin
      m_en = 0;
    end
    m_pulse = (m_en != en0) || (m_dir != d0);
    m_prev = m_lvl;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] >= D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(btn, stop);
    #1;
    check_eq("enable", enable, m_en);
    check_eq("direc", direc, m_dir);
    check_eq("change_pulse", change_pulse, m_pulse);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic wait_enable(input string tag);
    int unsigned g;
    g = 0;
    while (!enable && g < 40) begin tick(); g++; end
    check_eq(tag, enable, 1);
  endtask

  task automatic count_high(input string tag);
    int unsigned hi;
    hi = 0;
    for (int k = 0; k < 60 && enable; k++) begin hi++; tick(); end
    check_eq(tag, hi, H);
  endtask

  initial begin
    int unsigned g;
    int unsigned tgt;
    int unsigned p;
    rst_n = 1'b0; btn = '0; stop = 1'b0;
    model_reset();

    // reset and basic latency / hold length
    ticks(3);
    check_eq("rst_enable", enable, 0);
    check_eq("rst_direc", direc, 0);
    check_eq("rst_pulse", change_pulse, 0);
    rst_n = 1'b1;
    btn = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check_eq("lat_pre", enable, 0);
      if (k == 7) begin
        check_eq("lat_en", enable, 1);
        check_eq("lat_dir", direc, 1);
        check_eq("lat_pulse", change_pulse, 1);
      end
    end
    count_high("hold_len");
    check_eq("dir_kept", direc, 1);

    // bounce rejection on forward
    btn = '0;
    ticks(10);
    for (int c = 0; c < 30; c++) begin
      btn[0] = ((c / 3) % 2 == 0);
      tick();
      check_eq("bounce_noen", enable, 0);
    end
    btn[0] = 1'b1;
    wait_enable("bounce_en");
    check_eq("bounce_dir", direc, 0);
    ticks(25);

    // simultaneous presses, then right while moving
    btn = '0;
    ticks(10);
    btn = 4'b1101;
    wait_enable("prio_en");
    check_eq("prio_dir", direc, 0);
    btn = '0;
    ticks(8);
    btn = 4'b1000;
    g = 0;
    while (direc != 2'd3 && g < 20) begin tick(); g++; end
    check_eq("right_dir", direc, 3);
    check_eq("right_en", enable, 1);

    // same-direction retrigger landing on the timeout cycle
    btn = '0;
    tgt = m_deadline - (D + 3);
    g = 0;
    while (m_n < tgt && g < 100) begin tick(); g++; end
    btn = 4'b1000;
    ticks(D + 3);
    check_eq("retrig_en", enable, 1);
    check_eq("retrig_nopulse", change_pulse, 0);
    count_high("retrig_len");

    // stop while moving, then press during stop
    btn = '0;
    ticks(8);
    btn = 4'b0100;
    wait_enable("stop_en");
    p = m_n;
    while (m_n < p + 5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_off", enable, 0);
    check_eq("stop_pulse", change_pulse, 1);
    btn = '0;
    ticks(8);
    stop = 1'b1;
    btn = 4'b0001;
    ticks(12);
    stop = 1'b0;
    ticks(3);
    check_eq("stop_ignored", enable, 0);
    check_eq("stop_dir", direc, 2);

    // async reset mid-move with buttons held
    btn = '0;
    ticks(8);
    btn = 4'b0100;
    wait_enable("rst_mv_en");
    ticks(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_en", enable, 0);
    check_eq("async_dir", direc, 0);
    check_eq("async_pulse", change_pulse, 0);
    ticks(4);
    rst_n = 1'b1;
    g = 0;
    while (!enable && g < 20) begin tick(); g++; end
    check_eq("rst_relat", g, 7);
    check_eq("rst_re_dir", direc, 2);

    // randomised phase
    for (int s = 0; s < 500; s++) begin
      case ($urandom_range(0, 3))
        0:       btn = '0;
        1:       btn = 4'(1 << $urandom_range(0, 3));
        2:       btn = 4'($urandom);
        default: ;
      endcase
      for (int unsigned k = 0; k < $urandom_range(1, 12); k++) begin
        stop = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    stop = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/direction_cmd_fsm.md
Name: direction_cmd_fsm

Overview:
- Upstream command stage for the direction display. Turns four raw push-button inputs into a latched 2-bit direction code and a display/motion enable.
- Each bit is synchronised, debounced and edge-detected. A timed MOVING state holds the command for a fixed duration, then drops enable.
- Outputs drive the display's enable/direc inputs and the motor-drive logic directly.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised input must differ from its debounced level before the debounced level changes (1 ms at 50 MHz). Must be ≥1.
- HOLD_CYCLES, 50000000: cycles enable stays high after the last accepted press (1 s at 50 MHz). Must be ≥2.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- btn, input, 4: raw buttons, active-high, asynchronous. [0]=forward, [1]=reverse, [2]=left, [3]=right.
- stop, input, 1: synchronous active-high abort.
- enable, output, 1: high while in MOVING.
- direc, output, 2: direction code. 00=forward, 01=reverse, 10=left, 11=right.
- change_pulse, output, 1: one-cycle strobe when enable or direc changes.

Behaviour:
- Reset (async, rst_n=0) clears all of the following immediately:
  - sync flops, debounced levels, debounce counters, hold counter
  - state=IDLE, enable=0, direc=00, change_pulse=0
- Reset asserted mid-move aborts with no pulse. After release, the first edge behaves as post-reset.
- Input conditioning (per bit, independent):
  - 2-flop synchroniser; then a debounce counter that increments while sync2 != db and clears when they are equal.
  - db toggles on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then clears.
  - press[i] = db[i] & ~db_q[i] (combinational, single cycle). Releases generate no event.
- Press priority when several occur on the same cycle: forward > reverse > left > right. Lower-priority presses that cycle are discarded.
- Latency: count the first edge sampling btn[i]=1 as edge 1. With btn held clean, enable/direc update on edge DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES cycles at sync2 produce no press.
- State IDLE:
  - enable=0; direc holds its last value.
  - On a press with stop=0: latch the code into direc, hold_cnt←0, go to MOVING.
- State MOVING:
  - enable=1; hold_cnt increments each cycle.
  - Press with stop=0: latch the new code (same or different), hold_cnt←0, stay in MOVING.
  - Otherwise, hold_cnt==HOLD_CYCLES-1 → go to IDLE.
  - Net effect: enable stays high exactly HOLD_CYCLES cycles after the last accepted press.
- Priority within a cycle: stop > press > timeout.
  - stop=1 in MOVING → IDLE next edge.
  - stop=1 in IDLE → no change. Presses while stop=1 are discarded, not queued.
  - A press on the timeout cycle retriggers; enable never drops.
- change_pulse: registered. High for the one cycle after an edge where enable or direc changed value.
  - A same-direction retrigger gives no pulse.
  - IDLE→MOVING with an unchanged direc gives a pulse (enable changed).
- hold_cnt width: $clog2(HOLD_CYCLES). Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). No wrap is reachable.

Test Plan:
- Reset/basic (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20): rst_n low then high; hold btn=0010 clean from edge 1 → enable=1, direc=01 after edge 7, change_pulse high for one cycle, enable returns to 0 after exactly 20 cycles high, direc stays 01.
- Bounce rejection: btn[0] toggles with 3-cycle highs/lows for 30 cycles, then stays high → no enable until 4 stable sync2 cycles elapse, then direc=00, enable=1, single change_pulse.
- Simultaneous/priority: btn 1100 and 0001 rise on the same edge → direc=00. Later release all and press btn[3] only while MOVING → direc=11, hold_cnt restarts, one change_pulse, enable continuous.
- Retrigger at timeout: a press lands on the hold_cnt==19 cycle → enable never drops, next drop is 20 cycles later. A same-direction retrigger gives no change_pulse.
- Stop: in MOVING at hold_cnt=5 assert stop for 1 cycle → enable=0 next edge, change_pulse once. A press debounced while stop=1 → ignored, remains IDLE.
- Async reset mid-move: drop rst_n between clock edges while enable=1, direc=10 → enable=0 and direc=00 immediately without a clock. Buttons held through reset generate a press only after a fresh debounce.
